// File: rtl/dataframe_parser.sv
// Receive-side dataframe parser: validates header/payload/footer structure,
// forwards payload beats and packs header/footer words for the HF FIFO.
module dataframe_parser #(
  parameter int DATAFRAME_WIDTH    = 64,
  parameter int RFDC_TDATA_WIDTH   = 128,
  parameter int HEADER_LINE        = 2,
  parameter int FOOTER_LINE        = 1,
  parameter int HEADER_ID_WIDTH    = 8,
  parameter int CH_ID_WIDTH        = 8,
  parameter int FRAME_LENGTH_WIDTH = 12
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic                        S_AXIS_TVALID,
  input  logic [RFDC_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                        S_AXIS_TLAST,
  output logic                        S_AXIS_TREADY,
  output logic                        M_AXIS_TVALID,
  output logic [RFDC_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                        M_AXIS_TLAST,
  output logic                        M_AXIS_TUSER,
  input  logic                        M_AXIS_TREADY,
  input  logic                        HF_FIFO_FULL,
  output logic                        HF_FIFO_WR_EN,
  output logic [(HEADER_LINE+FOOTER_LINE)*DATAFRAME_WIDTH-1:0] HF_DATA,
  output logic                        PARSER_ERROR,
  output logic [15:0]                 ERROR_CNT,
  output logic [31:0]                 FRAME_CNT
);

  localparam int DW    = DATAFRAME_WIDTH;
  localparam int FLW   = FRAME_LENGTH_WIDTH;
  localparam int HF_W  = (HEADER_LINE+FOOTER_LINE)*DW;
  localparam int FL_HI = DW-1-HEADER_ID_WIDTH-CH_ID_WIDTH;
  localparam int IDX_W = (HEADER_LINE > 1) ? $clog2(HEADER_LINE) : 1;

  typedef enum logic [1:0] {
    HEADER, PAYLOAD, FOOTER, DROP
  } state_t;

  state_t state, state_nxt;

  logic             rdy_en;
  logic [IDX_W-1:0] hdr_idx;
  logic [FLW-1:0]   frame_len;
  logic [FLW-1:0]   cnt;

  logic [DW-1:0]  word;
  logic [FLW-1:0] len_fld;
  logic [FLW-1:0] len_cur;
  logic           marker_ok;
  logic           acc;
  logic           hdr_last;
  logic           pay_last;

  logic hdr_st, ftr_st, m_load, m_last, m_user;
  logic err_nxt, good_nxt;

  assign word      = S_AXIS_TDATA[DW-1:0];
  assign marker_ok = &S_AXIS_TDATA[RFDC_TDATA_WIDTH-1:DW];
  assign len_fld   = word[FL_HI -: FLW];
  assign len_cur   = (hdr_idx == '0) ? len_fld : frame_len;
  assign hdr_last  = (hdr_idx == IDX_W'(HEADER_LINE-1));
  assign pay_last  = (cnt == frame_len - FLW'(1));

  always_comb begin
    S_AXIS_TREADY = 1'b0;
    unique case (state)
      HEADER:  S_AXIS_TREADY = rdy_en;
      DROP:    S_AXIS_TREADY = rdy_en;
      PAYLOAD: S_AXIS_TREADY = rdy_en & (!M_AXIS_TVALID | M_AXIS_TREADY);
      FOOTER:  S_AXIS_TREADY = rdy_en & !HF_FIFO_FULL;
      default: S_AXIS_TREADY = 1'b0;
    endcase
  end

  assign acc = S_AXIS_TVALID & S_AXIS_TREADY;

  always_comb begin
    state_nxt = state;
    hdr_st    = 1'b0;
    ftr_st    = 1'b0;
    m_load    = 1'b0;
    m_last    = 1'b0;
    m_user    = 1'b0;
    err_nxt   = 1'b0;
    good_nxt  = 1'b0;
    unique case (state)
      HEADER: if (acc) begin
        hdr_st = 1'b1;
        if (!marker_ok) begin
          err_nxt   = 1'b1;
          state_nxt = S_AXIS_TLAST ? HEADER : DROP;
        end else if (S_AXIS_TLAST) begin
          err_nxt   = 1'b1;
          state_nxt = HEADER;
        end else if (hdr_last) begin
          state_nxt = (len_cur != '0) ? PAYLOAD : FOOTER;
        end
      end
      PAYLOAD: if (acc) begin
        m_load = 1'b1;
        if (pay_last) begin
          m_last    = 1'b1;
          state_nxt = FOOTER;
        end else if (S_AXIS_TLAST) begin
          m_last    = 1'b1;
          m_user    = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = HEADER;
        end
      end
      FOOTER: if (acc) begin
        if (marker_ok && S_AXIS_TLAST) begin
          ftr_st    = 1'b1;
          good_nxt  = 1'b1;
          state_nxt = HEADER;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = S_AXIS_TLAST ? HEADER : DROP;
        end
      end
      DROP: if (acc && S_AXIS_TLAST) state_nxt = HEADER;
      default: state_nxt = HEADER;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= HEADER;
      rdy_en        <= 1'b0;
      hdr_idx       <= '0;
      frame_len     <= '0;
      cnt           <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TUSER  <= 1'b0;
      HF_FIFO_WR_EN <= 1'b0;
      HF_DATA       <= '0;
      PARSER_ERROR  <= 1'b0;
      ERROR_CNT     <= '0;
      FRAME_CNT     <= '0;
    end else begin
      state         <= state_nxt;
      rdy_en        <= 1'b1;
      HF_FIFO_WR_EN <= ftr_st;
      PARSER_ERROR  <= err_nxt;
      if (hdr_st) begin
        hdr_idx <= (state_nxt == HEADER && !err_nxt) ? hdr_idx + 1'b1 : '0;
        if (hdr_idx == '0) frame_len <= len_fld;
        for (int i = 0; i < HEADER_LINE; i++)
          if (hdr_idx == IDX_W'(i)) HF_DATA[HF_W-1-i*DW -: DW] <= word;
      end
      if (ftr_st) HF_DATA[DW-1:0] <= word;
      // single output slot: refilled only when empty or draining
      if (m_load) begin
        cnt           <= (state_nxt == PAYLOAD) ? cnt + 1'b1 : '0;
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TDATA  <= S_AXIS_TDATA;
        M_AXIS_TLAST  <= m_last;
        M_AXIS_TUSER  <= m_user;
      end else if (M_AXIS_TREADY) begin
        M_AXIS_TVALID <= 1'b0;
      end
      if (err_nxt && ERROR_CNT != '1) ERROR_CNT <= ERROR_CNT + 1'b1;
      if (good_nxt) FRAME_CNT <= FRAME_CNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_dataframe_parser.sv
// Bench for dataframe_parser: frame-level model with queues of expected
// payload beats and HF entries, random frame kinds and backpressure.
module tb_dataframe_parser;

  localparam int DW  = 64;
  localparam int TW  = 128;
  localparam int HL  = 2;
  localparam int HFW = 3*DW;

  logic           ACLK = 1'b0;
  logic           ARESETN = 1'b0;
  logic           S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
  logic [TW-1:0]  S_AXIS_TDATA;
  logic           M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TREADY;
  logic [TW-1:0]  M_AXIS_TDATA;
  logic           HF_FIFO_FULL, HF_FIFO_WR_EN, PARSER_ERROR;
  logic [HFW-1:0] HF_DATA;
  logic [15:0]    ERROR_CNT;
  logic [31:0]    FRAME_CNT;

  dataframe_parser dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TDATA(S_AXIS_TDATA),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TREADY(M_AXIS_TREADY), .HF_FIFO_FULL(HF_FIFO_FULL),
    .HF_FIFO_WR_EN(HF_FIFO_WR_EN), .HF_DATA(HF_DATA),
    .PARSER_ERROR(PARSER_ERROR), .ERROR_CNT(ERROR_CNT),
    .FRAME_CNT(FRAME_CNT)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [TW-1:0] d;
    logic          l;
    logic          u;
  } mbeat_t;

  mbeat_t         mq[$];
  logic [HFW-1:0] hq[$];
  mbeat_t         e;
  logic [HFW-1:0] he;

  int n_cmp = 0, n_fail = 0;
  int exp_err = 0, exp_frames = 0, err_pulses = 0;
  int phase = 0, bp_mode = 0, hf_force = 0;
  bit ignore_m = 1'b0;

  task automatic chk(input string nm, input logic [HFW-1:0] act,
                     input logic [HFW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk(input logic [DW-1:0] w);
    return {{DW{1'b1}}, w};
  endfunction

  function automatic logic [TW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] hdr0(input int len);
    logic [DW-1:0] w;
    w = {$urandom, $urandom};
    w[47:36] = len[11:0];
    return w;
  endfunction

  function automatic void pushm(input logic [TW-1:0] d, input logic l,
                                input logic u);
    mbeat_t b;
    b.d = d; b.l = l; b.u = u;
    mq.push_back(b);
  endfunction

  // downstream ready / HF full generator
  always @(posedge ACLK) begin
    #1;
    case (bp_mode)
      0:       M_AXIS_TREADY = 1'b1;
      1:       M_AXIS_TREADY = ~M_AXIS_TREADY;
      default: M_AXIS_TREADY = ($urandom_range(0, 2) != 0);
    endcase
    if (hf_force > 0) begin
      HF_FIFO_FULL = 1'b1;
      hf_force--;
    end else begin
      HF_FIFO_FULL = (bp_mode == 2) && ($urandom_range(0, 3) == 0);
    end
  end

  // single compare process
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (M_AXIS_TVALID && M_AXIS_TREADY && !ignore_m) begin
        if (mq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL m_extra: got %0h want none", M_AXIS_TDATA);
        end else begin
          e = mq.pop_front();
          chk("m_beat", {M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TUSER},
              {e.d, e.l, e.u});
        end
      end
      if (HF_FIFO_WR_EN && !ignore_m) begin
        if (hq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL hf_extra: got %0h want none", HF_DATA);
        end else begin
          he = hq.pop_front();
          chk("hf_data", HF_DATA, he);
        end
      end
      if (PARSER_ERROR) err_pulses++;
      if (S_AXIS_TVALID) begin
        if (phase == 1) chk("rdy_hdr", S_AXIS_TREADY, 1);
        if (phase == 2 && M_AXIS_TVALID && !M_AXIS_TREADY)
          chk("rdy_stall", S_AXIS_TREADY, 0);
        if (phase == 3) chk("rdy_ftr", S_AXIS_TREADY, !HF_FIFO_FULL);
      end
    end
  end

  task automatic send(input logic [TW-1:0] d, input logic l, input int ph);
    int  t;
    logic ok;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = d;
    S_AXIS_TLAST  = l;
    phase         = ph;
    t = 0;
    do begin
      @(negedge ACLK);
      ok = S_AXIS_TREADY;
      @(posedge ACLK);
      #1;
      t++;
    end while (!ok && t < 300);
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL s_timeout: got tready 0 want 1");
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    phase         = 0;
  endtask

  task automatic send_pay(input int len, input int tk);
    logic [TW-1:0] d;
    logic l;
    for (int j = 0; j < len; j++) begin
      if (tk >= 0 && j > tk) break;
      d = rnd();
      l = (j == tk);
      pushm(d, (j == len-1) || l, l);
      send(d, l, 2);
    end
  endtask

  task automatic junk();
    int n;
    n = $urandom_range(0, 3);
    for (int j = 0; j < n; j++) send(rnd(), 1'b0, 1);
    send(rnd(), 1'b1, 1);
  endtask

  task automatic rand_frame(input int kind);
    int len, i;
    logic [DW-1:0] h0, h1, f;
    logic [TW-1:0] b;
    logic tl;
    len = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 24)
                                      : $urandom_range(0, 5);
    if (kind == 1) len = $urandom_range(2, 6);
    h0 = hdr0(len);
    h1 = {$urandom, $urandom};
    f  = {$urandom, $urandom};
    case (kind)
      0: begin
        send(mk(h0), 0, 1); send(mk(h1), 0, 1);
        send_pay(len, -1);
        hq.push_back({h0, h1, f});
        send(mk(f), 1, 3);
        exp_frames++;
      end
      1: begin
        send(mk(h0), 0, 1); send(mk(h1), 0, 1);
        send_pay(len, $urandom_range(0, len-2));
        exp_err++;
      end
      2: begin
        i = $urandom_range(0, HL-1);
        if (i == 1) send(mk(h0), 0, 1);
        b = rnd();
        b[DW] = 1'b0;
        tl = 1'($urandom_range(0, 1));
        send(b, tl, 1);
        if (!tl) junk();
        exp_err++;
      end
      3: begin
        i = $urandom_range(0, HL-1);
        if (i == 1) send(mk(h0), 0, 1);
        send(mk(i == 1 ? h1 : h0), 1, 1);
        exp_err++;
      end
      4: begin
        send(mk(h0), 0, 1); send(mk(h1), 0, 1);
        send_pay(len, -1);
        b = rnd();
        b[TW-1] = 1'b0;
        send(b, 1, 3);
        exp_err++;
      end
      default: begin
        send(mk(h0), 0, 1); send(mk(h1), 0, 1);
        send_pay(len, -1);
        b = ($urandom_range(0, 1) == 0) ? mk(f) : rnd();
        send(b, 0, 3);
        junk();
        exp_err++;
      end
    endcase
  endtask

  // directed good frame with payload beats 0..len-1
  task automatic good_lit(input logic [DW-1:0] h0, input int len,
                          input logic [DW-1:0] f, input int stall);
    send(mk(h0), 0, 1);
    send(mk(64'h1111), 0, 1);
    for (int j = 0; j < len; j++) begin
      pushm(TW'(j), j == len-1, 1'b0);
      send(TW'(j), 0, 2);
    end
    hq.push_back({h0, 64'h1111, f});
    hf_force = stall;
    send(mk(f), 1, 3);
    exp_frames++;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((mq.size() != 0 || hq.size() != 0) && t < 1000) begin
      @(posedge ACLK);
      t++;
    end
    repeat (4) @(posedge ACLK);
    #1;
    chk("drain_m", mq.size(), 0);
    chk("drain_hf", hq.size(), 0);
  endtask

  initial begin
    S_AXIS_TVALID = 0; S_AXIS_TDATA = '0; S_AXIS_TLAST = 0;
    M_AXIS_TREADY = 1; HF_FIFO_FULL = 0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_tready", S_AXIS_TREADY, 0);
    chk("rst_mvalid", M_AXIS_TVALID, 0);
    chk("rst_hfwr", HF_FIFO_WR_EN, 0);
    chk("rst_errcnt", ERROR_CNT, 0);
    chk("rst_framecnt", FRAME_CNT, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    chk("rel_tready0", S_AXIS_TREADY, 0);
    @(posedge ACLK);
    #1;
    chk("rel_tready1", S_AXIS_TREADY, 1);

    good_lit(64'hAA01_0040_0000_0000, 4, 64'h2222, 0);
    drain();
    chk("t1_frames", FRAME_CNT, 32'd1);
    chk("t1_errs", ERROR_CNT, 16'd0);

    bp_mode = 1;
    good_lit(64'hAA01_0040_0000_0000, 4, 64'h2222, 3);
    drain();
    bp_mode = 0;
    chk("t2_frames", FRAME_CNT, 32'd2);

    send(mk(64'hAA01_0040_0000_0000), 0, 1);
    send(mk(64'h1111), 0, 1);
    pushm(TW'(0), 0, 0); send(TW'(0), 0, 2);
    pushm(TW'(1), 0, 0); send(TW'(1), 0, 2);
    pushm(TW'(2), 1, 1); send(TW'(2), 1, 2);
    exp_err++;
    drain();
    chk("t3_errs", ERROR_CNT, 16'd1);
    chk("t3_pulses", err_pulses, 1);
    good_lit(64'hAA01_0040_0000_0000, 4, 64'h2222, 0);
    drain();
    chk("t3_frames", FRAME_CNT, 32'd3);

    send(mk(64'hAA01_0040_0000_0000), 0, 1);
    send({64'h0, 64'h1111}, 0, 1);
    send(mk(64'h5), 0, 1);
    send(rnd(), 1, 1);
    exp_err++;
    drain();
    chk("t4_errs", ERROR_CNT, 16'd2);
    chk("t4_frames", FRAME_CNT, 32'd3);

    good_lit(64'hAA01_0000_0000_0000, 0, 64'h3333, 0);
    drain();
    chk("t5_frames", FRAME_CNT, 32'd4);

    bp_mode = 2;
    for (int k = 0; k < 60; k++) rand_frame($urandom_range(0, 5));
    bp_mode = 0;
    drain();
    chk("rand_errs", ERROR_CNT, exp_err);
    chk("rand_frames", FRAME_CNT, exp_frames);
    chk("rand_pulses", err_pulses, exp_err);

    ignore_m = 1'b1;
    send(mk(hdr0(6)), 0, 1);
    send(mk(64'h1111), 0, 1);
    send(rnd(), 0, 2);
    send(rnd(), 0, 2);
    #2;
    ARESETN = 1'b0;
    #1;
    chk("ar_tready", S_AXIS_TREADY, 0);
    chk("ar_mout", {M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TUSER}, 0);
    chk("ar_hfwr", HF_FIFO_WR_EN, 0);
    chk("ar_hfdata", HF_DATA, 0);
    chk("ar_perr", PARSER_ERROR, 0);
    chk("ar_errcnt", ERROR_CNT, 0);
    chk("ar_framecnt", FRAME_CNT, 0);
    mq.delete();
    hq.delete();
    exp_err = 0; exp_frames = 0; err_pulses = 0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    chk("ar_rel0", S_AXIS_TREADY, 0);
    @(posedge ACLK);
    #1;
    chk("ar_rel1", S_AXIS_TREADY, 1);
    ignore_m = 1'b0;
    rand_frame(0);
    drain();
    chk("ar_frames", FRAME_CNT, 32'd1);
    chk("ar_errs", ERROR_CNT, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
